sar_adc_ctrl: RTL and testbench
===============================

// Module: sar_adc_ctrl
// PURPOSE
//  Successive-approximation control logic: the capture side that pairs with the 10-bit avsddac.
//  Drives the DAC code D, reads an analog comparator (Vin vs DAC OUT), and resolves one bit per step, MSB first.
//  Sits between the RVMyth core (start/result) and the analog DAC + comparator + track/hold.
// PARAMETERS
//  WIDTH          10  resolution in bits; width of dac_code and result
//  SAMPLE_CYCLES  4   cycles track_hold stays high per conversion (>=1)
//  SETTLE_CYCLES  2   wait cycles after each dac_code update before cmp_in is used (>=0)
// PORTS
//  clk           in   1      single clock; all state changes on rising edge
//  reset         in   1      asynchronous, active-high reset
//  start         in   1      request conversion; sampled only in IDLE
//  cmp_in        in   1      comparator: 1 = Vin >= Vdac; synchronous to clk
//  dac_code      out  WIDTH  trial code to DAC input D
//  track_hold    out  1      1 = track Vin, 0 = hold
//  busy          out  1      high in every state except IDLE
//  done          out  1      one-cycle pulse when result updates
//  result        out  WIDTH  last completed conversion
//  result_valid  out  1      high from done until next accepted start
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; dac_code, result = 0; track_hold, busy, done, result_valid = 0; counters and SAR reg cleared.
//  FSM: IDLE -> SAMPLE -> {SETTLE -> DECIDE} x WIDTH -> DONE -> IDLE.
//  IDLE: start=1 at edge -> SAMPLE; result_valid cleared same edge. start=0 -> stay.
//  SAMPLE: track_hold=1, dac_code=0, for exactly SAMPLE_CYCLES cycles. Then bit index i=WIDTH-1.
//   Leaving SAMPLE sets dac_code = {sar | 1<<i} (trial) and enters SETTLE.
//  SETTLE: hold dac_code for SETTLE_CYCLES cycles; with SETTLE_CYCLES=0 go straight to DECIDE.
//  DECIDE (1 cycle): sample cmp_in. 1 -> sar[i]=1 (keep); 0 -> sar[i]=0.
//   i>0: i--, dac_code = new trial, back to SETTLE. i==0: -> DONE.
//  DONE (1 cycle): result=sar; done=1; result_valid=1; dac_code retains final code; then IDLE.
//  Latency, start-accepting edge to done high: SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) + 1 cycles (35 at defaults).
//  start while busy: ignored, no queuing. start held high: a new conversion begins the edge after DONE.
//  result never changes outside DONE; stays stable through following conversions until their DONE.
//  Arithmetic: unsigned binary codes; code k maps to VREFL + k/(2^WIDTH-1)*(VREFH-VREFL). No bit beyond WIDTH-1 ever set.
//  Reset mid-conversion: immediate abort to reset values; no done pulse; partial code discarded.
// CONFIGURATION
//  SAR_ADC_AVG_EN defined: each accepted start runs 4 back-to-back full conversions (each with SAMPLE phase).
//   Per-conversion codes summed in a WIDTH+2-bit accumulator; result = acc>>2 (truncating).
//   done/result_valid only after the 4th; busy high throughout.
//   Latency = 4*(SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1)) + 1 (137 at defaults).
//   Reset clears the accumulator.
//  Not defined: single conversion per start; no accumulator logic present.
// TESTING
//  Comparator model: cmp_in = (TARGET >= dac_code), registered-free.
//  1: TARGET=0 (cmp_in always 0 for trials), pulse start -> done at cycle 35; result=0x000; trial codes 0x200,0x100,...,0x001.
//  2: cmp_in tied 1, start -> result=0x3FF; result_valid=1; busy low the cycle after done.
//  3: TARGET=681 (0x2A9) -> result=0x2A9; dac_code sequence 0x200,0x300,0x280,0x2C0,0x2A0,0x2B0,0x2A8,0x2AC,0x2AA,0x2A9.
//  4: TARGET=512, re-pulse start at cycles 5 and 20 of conversion -> single done, result=0x200; no second conversion.
//  5: assert reset at cycle 17 of conversion -> all outputs 0 same cycle (async); no done; next start converts TARGET=100 -> 100.
//  6: SAR_ADC_AVG_EN, TARGET stepped 100,101,102,103 per conversion -> single done at cycle 137; result=101.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// SAR ADC sequencer: drives DAC trial codes MSB-first and resolves each bit from the comparator.
// Latency start->done: SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) + 1; SAR_ADC_AVG_EN runs 4 conversions and averages them.
// No backpressure: start is sampled only in IDLE and is dropped while busy, nothing is queued.
module sar_adc_ctrl #(
    parameter int WIDTH         = 10,
    parameter int SAMPLE_CYCLES = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] dac_code,
    output logic             track_hold,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid
);

    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MSB_MASK    = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_DONE
    } state_t;

    // With no settle time a fresh trial code is decided on the very next cycle.
    localparam state_t AFTER_TRIAL = (SETTLE_CYCLES == 0) ? ST_DECIDE : ST_SETTLE;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] sar_q, sar_d;
    logic [WIDTH-1:0] dac_d;
    logic [WIDTH-1:0] result_d;
    logic             done_d;
    logic             result_valid_d;
    logic [WIDTH-1:0] trial_mask;
    logic [WIDTH-1:0] decided;

`ifdef SAR_ADC_AVG_EN
    logic [WIDTH+1:0] acc_q, acc_d;
    logic [1:0]       conv_q, conv_d;
`endif

    assign busy       = (state_q != ST_IDLE);
    assign track_hold = (state_q == ST_SAMPLE);

    // sar_q holds zeros at and below the bit under test, so OR-ing the mask forms the trial.
    assign trial_mask = WIDTH'(1) << idx_q;
    assign decided    = cmp_in ? (sar_q | trial_mask) : sar_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            sar_q        <= '0;
            dac_code     <= '0;
            result       <= '0;
            done         <= 1'b0;
            result_valid <= 1'b0;
`ifdef SAR_ADC_AVG_EN
            acc_q        <= '0;
            conv_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sar_q        <= sar_d;
            dac_code     <= dac_d;
            result       <= result_d;
            done         <= done_d;
            result_valid <= result_valid_d;
`ifdef SAR_ADC_AVG_EN
            acc_q        <= acc_d;
            conv_q       <= conv_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        sar_d          = sar_q;
        dac_d          = dac_code;
        result_d       = result;
        done_d         = 1'b0;
        result_valid_d = result_valid;
`ifdef SAR_ADC_AVG_EN
        acc_d          = acc_q;
        conv_d         = conv_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d        = ST_SAMPLE;
                    cnt_d          = '0;
                    sar_d          = '0;
                    dac_d          = '0;
                    result_valid_d = 1'b0;
`ifdef SAR_ADC_AVG_EN
                    acc_d          = '0;
                    conv_d         = '0;
`endif
                end
            end

            ST_SAMPLE: begin
                if (cnt_q == SAMPLE_LAST) begin
                    state_d = AFTER_TRIAL;
                    cnt_d   = '0;
                    idx_d   = IDX_MSB;
                    dac_d   = MSB_MASK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_DECIDE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DECIDE: begin
                sar_d = decided;
                if (idx_q != '0) begin
                    state_d = AFTER_TRIAL;
                    cnt_d   = '0;
                    idx_d   = idx_q - 1'b1;
                    dac_d   = decided | (trial_mask >> 1);
                end else begin
`ifdef SAR_ADC_AVG_EN
                    acc_d = acc_q + {2'b00, decided};
                    if (conv_q == 2'd3) begin
                        state_d = ST_DONE;
                        dac_d   = decided;
                    end else begin
                        // Next conversion re-tracks the input from a clean SAR register.
                        state_d = ST_SAMPLE;
                        conv_d  = conv_q + 1'b1;
                        cnt_d   = '0;
                        sar_d   = '0;
                        dac_d   = '0;
                    end
`else
                    state_d = ST_DONE;
                    dac_d   = decided;
`endif
                end
            end

            ST_DONE: begin
                state_d        = ST_IDLE;
                done_d         = 1'b1;
                result_valid_d = 1'b1;
`ifdef SAR_ADC_AVG_EN
                result_d       = acc_q[WIDTH+1:2];
`else
                result_d       = sar_q;
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: ideal comparator, timeline reference model, directed and random conversions.
module tb_sar_adc_ctrl;

    localparam int W  = 10;
    localparam int SC = 4;
    localparam int ST = 2;
    localparam int P  = ST + 1;
    localparam int CL = SC + W * P;
`ifdef SAR_ADC_AVG_EN
    localparam int NC = 4;
`else
    localparam int NC = 1;
`endif
    localparam int TOT = NC * CL + 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         cmp_in;
    logic [W-1:0] dac_code;
    logic [W-1:0] result;
    logic         track_hold;
    logic         busy;
    logic         done;
    logic         result_valid;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int tgt_tab[4];
    bit cmp_en = 1'b0;

    // reference model state: position m (edges since accept) within the conversion timeline
    bit m_act;
    int m;
    int m_res;
    bit m_rv;
    bit m_done;
    bit m_dac_zero;
    int m_conv = 0;
    int trial_tab[4][W];
    int code_tab[4];

    logic [W-1:0] dac_seq[$];
    int last_lat;
    int t3_seq[W] = '{512, 768, 640, 704, 672, 688, 680, 684, 682, 681};

    sar_adc_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cmp_in      (cmp_in),
        .dac_code    (dac_code),
        .track_hold  (track_hold),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    assign cmp_in = (tgt_tab[m_conv] >= int'(dac_code));

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act = 0; m = 0; m_res = 0; m_rv = 0; m_done = 0; m_dac_zero = 1; m_conv = 0;
        end else begin
            m_done = 0;
            if (m_act) begin
                m = m + 1;
                if (m == TOT) begin
                    int sum;
                    sum = 0;
                    for (int c = 0; c < NC; c++) sum += code_tab[c];
                    m_res = sum / NC;
                    m_rv = 1; m_done = 1; m_act = 0; m_conv = 0;
                end else if (m < NC * CL) begin
                    m_conv = m / CL;
                end
            end else if (start === 1'b1) begin
                m_act = 1; m = 0; m_rv = 0; m_conv = 0; m_dac_zero = 0;
                for (int c = 0; c < NC; c++) begin
                    int code;
                    int t;
                    code = 0;
                    for (int j = 0; j < W; j++) begin
                        t = code + (1 << (W - 1 - j));
                        trial_tab[c][j] = t;
                        if (tgt_tab[c] >= t) code = t;
                    end
                    code_tab[c] = code;
                end
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int r;
        int exp_dac;
        int exp_th;
        if (cmp_en && reset === 1'b0) begin
            exp_th = (m_act && m < NC * CL && (m % CL) < SC) ? 1 : 0;
            check("busy", int'(busy), int'(m_act));
            check("track_hold", int'(track_hold), exp_th);
            check("done", int'(done), int'(m_done));
            check("result_valid", int'(result_valid), int'(m_rv));
            check("result", int'(result), m_res);
            if (m_act && m < NC * CL) begin
                r = m % CL;
                exp_dac = (r < SC) ? 0 : trial_tab[m / CL][(r - SC) / P];
                check("dac_code", int'(dac_code), exp_dac);
            end else if (!m_act && m_dac_zero) begin
                check("dac_code_idle", int'(dac_code), 0);
            end
        end
    end

    task automatic set_tgt(input int t);
        for (int c = 0; c < 4; c++) tgt_tab[c] = t;
    endtask

    task automatic run_conv();
        int acc_e;
        bit got;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc_e = edge_cnt;
        dac_seq.delete();
        got = 0;
        last_lat = -1;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (busy && !track_hold && (dac_seq.size() == 0 || dac_code != dac_seq[$]))
                dac_seq.push_back(dac_code);
            if (done) begin
                got = 1;
                last_lat = edge_cnt - acc_e;
            end
        end
        check("run_conv_done_seen", int'(got), 1);
    endtask

    task automatic wait_done();
        bit got;
        got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        check("wait_done_seen", int'(got), 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_track_hold"}, int'(track_hold), 0);
        check({tag, "_dac_code"}, int'(dac_code), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_result_valid"}, int'(result_valid), 0);
        check({tag, "_result"}, int'(result), 0);
    endtask

    initial begin
        int ndone;
        bit found;
        reset = 1'b1;
        start = 1'b0;
        set_tgt(0);
        repeat (2) @(negedge clk);
        check_zero_outputs("reset_state");
        #2 reset = 1'b0;
        cmp_en = 1'b1;

        // 1: comparator never trips, every trial bit is cleared
        set_tgt(0);
        run_conv();
        check("t1_latency", last_lat, (NC == 4) ? 137 : 35);
        check("t1_result", int'(result), 0);
        check("t1_result_valid", int'(result_valid), 1);
        for (int j = 0; j < W; j++)
            check($sformatf("t1_trial%0d", j), (j < dac_seq.size()) ? int'(dac_seq[j]) : -1, 512 >> j);

        // 2: full-scale input
        set_tgt(1023);
        run_conv();
        check("t2_result", int'(result), 1023);
        check("t2_result_valid", int'(result_valid), 1);
        @(negedge clk);
        check("t2_busy_after_done", int'(busy), 0);

        // 3: binary search path for 0x2A9
        set_tgt(681);
        run_conv();
        check("t3_result", int'(result), 681);
        for (int j = 0; j < W; j++)
            check($sformatf("t3_trial%0d", j), (j < dac_seq.size()) ? int'(dac_seq[j]) : -1, t3_seq[j]);

        // 4: start re-pulsed while busy is ignored
        set_tgt(512);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (14) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0;
        for (int i = 0; i < TOT + 60; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t4_done_count", ndone, 1);
        check("t4_result", int'(result), 512);
        check("t4_busy_end", int'(busy), 0);

        // 5: asynchronous reset in the middle of a conversion
        set_tgt(512);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_act && m == 17) found = 1;
            else @(negedge clk);
        end
        check("t5_reached_cycle17", int'(found), 1);
        #2 reset = 1'b1;
        #1 check_zero_outputs("t5_async_reset");
        @(negedge clk);
        #2 reset = 1'b0;
        set_tgt(100);
        run_conv();
        check("t5_result_after_reset", int'(result), 100);

`ifdef SAR_ADC_AVG_EN
        // 6: four stepped conversions averaged with truncation
        tgt_tab[0] = 100; tgt_tab[1] = 101; tgt_tab[2] = 102; tgt_tab[3] = 103;
        run_conv();
        check("t6_latency", last_lat, 137);
        check("t6_result", int'(result), 101);
`endif

        for (int it = 0; it < 40; it++) begin
            int mode;
            for (int c = 0; c < 4; c++) tgt_tab[c] = $urandom_range(0, 1023);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            mode = $urandom_range(0, 3);
            case (mode)
                0: run_conv();
                1: begin
                    @(negedge clk); start = 1'b1;
                    wait_done();
                    wait_done();
                    start = 1'b0;
                end
                2: begin
                    @(negedge clk); start = 1'b1;
                    @(negedge clk); start = 1'b0;
                    repeat ($urandom_range(1, 3)) begin
                        repeat ($urandom_range(1, 8)) @(negedge clk);
                        start = 1'b1;
                        @(negedge clk); start = 1'b0;
                    end
                    wait_done();
                end
                default: begin
                    @(negedge clk); start = 1'b1;
                    @(negedge clk); start = 1'b0;
                    repeat ($urandom_range(1, 30)) @(negedge clk);
                    #2 reset = 1'b1;
                    @(negedge clk);
                    #2 reset = 1'b0;
                end
            endcase
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
